ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 76 +++++++
 rtl/ex_stage_if.sv | 30 +++
 rtl/ex_stage_alu.sv | 54 +++++
 rtl/ex_stage.sv | 46 ++++
 tb/tb_ex_stage.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared pipeline types for the core: bus layout, opcode enums and width constants.
// Used by if_stage, id_stage and ex_stage alike.
package core;

    localparam int DATA_WIDTH = 32;
    localparam int DATA_BYTES = DATA_WIDTH / 8;

    typedef enum logic [4:0] {
        ALU_NOP   = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_SLL   = 5'd3,
        ALU_SRL   = 5'd4,
        ALU_SRA   = 5'd5,
        ALU_SLT   = 5'd6,
        ALU_SLTU  = 5'd7,
        ALU_XOR   = 5'd8,
        ALU_OR    = 5'd9,
        ALU_AND   = 5'd10,
        ALU_LUI   = 5'd11,
        ALU_AUIPC = 5'd12,
        ALU_JAL   = 5'd13,
        ALU_JALR  = 5'd14,
        ALU_BEQ   = 5'd15,
        ALU_BNE   = 5'd16,
        ALU_BLT   = 5'd17,
        ALU_BGE   = 5'd18,
        ALU_BLTU  = 5'd19,
        ALU_BGEU  = 5'd20
    } alu_op_t;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_t;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } format_t;

    typedef struct packed {
        logic [31:0]           instr;
        mem_op_t               mem_op;
        alu_op_t               alu_op;
        format_t               format;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [31:0]           pc;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] rd_res;
    } pipeline_bus_t;

    // Link value is the address of the next sequential instruction.
    localparam logic [DATA_WIDTH-1:0] LINK_OFFSET = DATA_WIDTH'(DATA_BYTES);

    // Only register-register and branch encodings take operand B from rs2.
    function automatic logic uses_rs2(input format_t fmt);
        return (fmt == FMT_R) || (fmt == FMT_B);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Operand/result bundle between the execute stage and its combinational ALU.
// master drives operands and reads the result; slave is the ALU side.
interface ex_stage_if;

    core::alu_op_t               alu_op;
    logic [core::DATA_WIDTH-1:0] op_a;
    logic [core::DATA_WIDTH-1:0] op_b;
    logic [core::DATA_WIDTH-1:0] pc;
    logic [core::DATA_WIDTH-1:0] imm;
    logic [core::DATA_WIDTH-1:0] result;

    modport master (
        output alu_op,
        output op_a,
        output op_b,
        output pc,
        output imm,
        input  result
    );

    modport slave (
        input  alu_op,
        input  op_a,
        input  op_b,
        input  pc,
        input  imm,
        output result
    );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational ALU: arithmetic/logic ops, upper-immediate and link values,
// and branch conditions reported as a single-bit result.
module alu
    import core::*;
(
    ex_stage_if.slave alu_bus
);

    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [4:0]            shamt;
    logic                  eq;
    logic                  lt_s;
    logic                  lt_u;
    logic [DATA_WIDTH-1:0] res;

    assign a     = alu_bus.op_a;
    assign b     = alu_bus.op_b;
    assign shamt = b[4:0];
    assign eq    = (a == b);
    assign lt_s  = ($signed(a) < $signed(b));
    assign lt_u  = (a < b);

    always_comb begin
        res = '0;
        case (alu_bus.alu_op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_SLL:   res = a << shamt;
            ALU_SRL:   res = a >> shamt;
            ALU_SRA:   res = $signed(a) >>> shamt;
            ALU_SLT:   res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU:  res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_XOR:   res = a ^ b;
            ALU_OR:    res = a | b;
            ALU_AND:   res = a & b;
            ALU_LUI:   res = alu_bus.imm;
            ALU_AUIPC: res = alu_bus.pc + alu_bus.imm;
            ALU_JAL,
            ALU_JALR:  res = alu_bus.pc + LINK_OFFSET;
            // Branches report only the taken flag; the target is computed elsewhere.
            ALU_BEQ:   res = {{(DATA_WIDTH-1){1'b0}}, eq};
            ALU_BNE:   res = {{(DATA_WIDTH-1){1'b0}}, ~eq};
            ALU_BLT:   res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_BGE:   res = {{(DATA_WIDTH-1){1'b0}}, ~lt_s};
            ALU_BLTU:  res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_BGEU:  res = {{(DATA_WIDTH-1){1'b0}}, ~lt_u};
            default:   res = '0;
        endcase
    end

    assign alu_bus.result = res;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: selects ALU operands, overrides the result with the effective
// address for loads/stores, and registers the whole bus for one cycle of latency.
module ex_stage
    import core::*;
(
    input  logic          clk,
    input  logic          rst,
    input  pipeline_bus_t bus_i,
    output pipeline_bus_t ex_bus_o
);

    ex_stage_if alu_bus ();

    logic [DATA_WIDTH-1:0] mem_addr;
    pipeline_bus_t         bus_d;
    pipeline_bus_t         bus_q;

    assign alu_bus.alu_op = bus_i.alu_op;
    assign alu_bus.op_a   = bus_i.rs1_data;
    assign alu_bus.op_b   = uses_rs2(bus_i.format) ? bus_i.rs2_data : bus_i.imm;
    assign alu_bus.pc     = bus_i.pc;
    assign alu_bus.imm    = bus_i.imm;

    alu u_alu (
        .alu_bus (alu_bus)
    );

    assign mem_addr = bus_i.rs1_data + bus_i.imm;

    // Memory ops always need the effective address, whatever alu_op says.
    always_comb begin
        bus_d        = bus_i;
        bus_d.rd_res = (bus_i.mem_op != MEM_NOP) ? mem_addr : alu_bus.result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_q <= '0;
        end else begin
            bus_q <= bus_d;
        end
    end

    assign ex_bus_o = bus_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected buses into a
// queue; a monitor pops and compares one cycle after each issued bus.
module tb_ex_stage;
    import core::*;

    localparam int BW = $bits(pipeline_bus_t);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    pipeline_bus_t bus_i;
    pipeline_bus_t ex_bus_o;

    logic          drv_valid = 1'b0;
    logic [BW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    ex_stage dut (
        .clk      (clk),
        .rst      (rst),
        .bus_i    (bus_i),
        .ex_bus_o (ex_bus_o)
    );

    always #5 clk = ~clk;

    function automatic pipeline_bus_t mk(input int id, input alu_op_t op, input mem_op_t mop,
                                         input format_t fmt, input logic [31:0] pc,
                                         input logic [31:0] imm, input logic [31:0] a,
                                         input logic [31:0] b);
        pipeline_bus_t r;
        r.instr    = 32'hA500_0000 | 32'(id);
        r.mem_op   = mop;
        r.alu_op   = op;
        r.format   = fmt;
        r.imm      = imm;
        r.rs1      = 5'(id);
        r.rs2      = 5'(id + 7);
        r.rd       = 5'(id + 13);
        r.pc       = pc;
        r.rs1_data = a;
        r.rs2_data = b;
        r.rd_res   = 32'hDEAD_BEEF;
        return r;
    endfunction

    // Applies a bus immediately, records its expected output, then waits for the next negedge.
    task automatic send(input pipeline_bus_t b, input logic [31:0] res);
        pipeline_bus_t e;
        bus_i     = b;
        drv_valid = 1'b1;
        e         = b;
        e.rd_res  = res;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (ex_bus_o !== '0) begin
            errors++;
            $display("FAIL %s got=%h expected all-zero", name, ex_bus_o);
        end
    endtask

    initial begin : monitor
        logic          pend;
        pipeline_bus_t e;
        forever begin
            @(posedge clk);
            pend = drv_valid;
            #1;
            if (pend) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got=%h", ex_bus_o);
                end else begin
                    e = exp_q.pop_front();
                    if (ex_bus_o !== e) begin
                        errors++;
                        $display("FAIL bus_instr_%h rd_res got=%h exp=%h full got=%h exp=%h",
                                 e.instr, ex_bus_o.rd_res, e.rd_res, ex_bus_o, e);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bus_i = mk(0, ALU_ADD, MEM_NOP, FMT_R, 32'h40, 32'h9, 32'h11, 32'h22);

        #1 rst = 1'b0;
        #1 check_zero("async_reset_no_edge");
        @(posedge clk);
        #1 check_zero("reset_held_over_edge");

        @(negedge clk);
        rst = 1'b1;
        send(mk(1, ALU_ADD, MEM_NOP, FMT_R, 32'h0, 32'h55, 32'h7FFF_FFFF, 32'h1), 32'h8000_0000);
        send(mk(2, ALU_SUB, MEM_NOP, FMT_R, 32'h4, 32'h55, 32'h0, 32'h1), 32'hFFFF_FFFF);
        send(mk(3, ALU_SRA, MEM_NOP, FMT_I, 32'h8, 32'h4, 32'h8000_0000, 32'h10), 32'hF800_0000);
        send(mk(4, ALU_SRL, MEM_NOP, FMT_I, 32'hC, 32'h4, 32'h8000_0000, 32'h10), 32'h0800_0000);
        send(mk(5, ALU_SLT, MEM_NOP, FMT_R, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'h1), 32'h1);
        send(mk(6, ALU_SLTU, MEM_NOP, FMT_R, 32'h14, 32'h0, 32'hFFFF_FFFF, 32'h1), 32'h0);
        send(mk(7, ALU_JAL, MEM_NOP, FMT_J, 32'h100, 32'h40, 32'h3, 32'h4), 32'h104);
        send(mk(8, ALU_AUIPC, MEM_NOP, FMT_U, 32'h100, 32'h2000, 32'h3, 32'h4), 32'h2100);
        send(mk(9, ALU_LUI, MEM_NOP, FMT_U, 32'h104, 32'h1234_5000, 32'h3, 32'h4), 32'h1234_5000);
        send(mk(10, ALU_NOP, MEM_LW, FMT_I, 32'h108, 32'hFFFF_FFFC, 32'h1000, 32'h7), 32'h0000_0FFC);
        send(mk(11, ALU_BNE, MEM_NOP, FMT_B, 32'h10C, 32'h8, 32'h5, 32'h5), 32'h0);
        send(mk(12, ALU_BEQ, MEM_NOP, FMT_B, 32'h110, 32'h8, 32'h5, 32'h5), 32'h1);
        send(mk(13, ALU_BLT, MEM_NOP, FMT_B, 32'h114, 32'h1, 32'hFFFF_FFFF, 32'h1), 32'h1);
        send(mk(14, ALU_BGE, MEM_NOP, FMT_B, 32'h118, 32'h1, 32'hFFFF_FFFF, 32'h1), 32'h0);
        send(mk(15, ALU_BLTU, MEM_NOP, FMT_B, 32'h11C, 32'h1, 32'hFFFF_FFFF, 32'h1), 32'h0);
        send(mk(16, ALU_BGEU, MEM_NOP, FMT_B, 32'h120, 32'h1, 32'hFFFF_FFFF, 32'h1), 32'h1);
        send(mk(17, ALU_SLL, MEM_NOP, FMT_I, 32'h124, 32'h21, 32'h1, 32'h0), 32'h2);
        send(mk(18, ALU_XOR, MEM_NOP, FMT_R, 32'h128, 32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00), 32'h0FF0_0FF0);
        send(mk(19, ALU_OR, MEM_NOP, FMT_R, 32'h12C, 32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00), 32'hFFF0_FFF0);
        send(mk(20, ALU_AND, MEM_NOP, FMT_R, 32'h130, 32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00), 32'hF000_F000);
        send(mk(21, ALU_JALR, MEM_NOP, FMT_I, 32'hFFFF_FFFC, 32'h10, 32'h3, 32'h4), 32'h0);
        send(mk(22, ALU_NOP, MEM_NOP, FMT_R, 32'h134, 32'h5, 32'h9, 32'h9), 32'h0);
        send(mk(23, alu_op_t'(5'd31), MEM_NOP, FMT_R, 32'h138, 32'h5, 32'h9, 32'h9), 32'h0);
        send(mk(24, ALU_ADD, MEM_SW, FMT_S, 32'h13C, 32'h20, 32'hFFFF_FFF0, 32'h77), 32'h10);
        send(mk(25, ALU_ADD, MEM_NOP, FMT_I, 32'h140, 32'hFFFF_FFFF, 32'h5, 32'h100), 32'h4);

        drv_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero("midstream_async_reset");
        @(posedge clk);
        #1 check_zero("midstream_reset_held");

        @(negedge clk);
        rst = 1'b1;
        send(mk(26, ALU_SUB, MEM_NOP, FMT_R, 32'h200, 32'h0, 32'h10, 32'h3), 32'hD);
        send(mk(27, ALU_AUIPC, MEM_NOP, FMT_U, 32'hFFFF_F000, 32'h2000, 32'h0, 32'h0), 32'h1000);
        drv_valid = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
